// File: rtl/mem_fill_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_fill_arbiter_pkg
// Shared definitions for the memory fill arbiter slice:
//   - default geometry (address/data width, words per cache block)
//   - FSM state encodings and cache-owner encodings
//   - block byte-offset width helper
// -----------------------------------------------------------------------------
package mem_fill_arbiter_pkg;

  localparam int DEF_ADDR_W          = 16;
  localparam int DEF_DATA_W          = 16;
  localparam int DEF_WORDS_PER_BLOCK = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // Byte-offset bits inside one block (a block is 2*wpb bytes).
  function automatic int blk_off_w(input int wpb);
    return $clog2(2 * wpb);
  endfunction

endpackage

// File: rtl/mem_fill_arbiter_block_fill_counter.sv
// -----------------------------------------------------------------------------
// mem_fill_arbiter_block_fill_counter
// Tracks progress of one block fill: how many reads have been issued and how
// many words have come back. Counters are one bit wider than the word offset
// so they can reach WORDS_PER_BLOCK without wrapping.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr_i          zero both counters (between fills)
//   issue_inc_i    a read was issued this cycle
//   ret_inc_i      a word returned this cycle
//   issue_cnt_o    reads issued so far
//   ret_word_o     word offset of the next returning word
//   last_issue_o   the read being issued now is the final one
//   last_ret_o     the word returning now is the final one
// -----------------------------------------------------------------------------
module mem_fill_arbiter_block_fill_counter #(
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr_i,
  input  logic                               issue_inc_i,
  input  logic                               ret_inc_i,
  output logic [$clog2(WORDS_PER_BLOCK):0]   issue_cnt_o,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] ret_word_o,
  output logic                               last_issue_o,
  output logic                               last_ret_o
);

  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);

  logic [CNT_W-1:0] issue_cnt_q;
  logic [CNT_W-1:0] issue_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q;
  logic [CNT_W-1:0] ret_cnt_d;

  // Next-count logic: clear between fills, saturate at a full block.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    if (clr_i) begin
      issue_cnt_d = '0;
      ret_cnt_d   = '0;
    end else begin
      if (issue_inc_i && (issue_cnt_q != CNT_FULL)) begin
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end else begin
        issue_cnt_d = issue_cnt_q;
      end
      if (ret_inc_i && (ret_cnt_q != CNT_FULL)) begin
        ret_cnt_d = ret_cnt_q + CNT_W'(1);
      end else begin
        ret_cnt_d = ret_cnt_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  assign issue_cnt_o  = issue_cnt_q;
  assign ret_word_o   = ret_cnt_q[OFF_W-1:0];
  assign last_issue_o = (issue_cnt_q == CNT_LAST);
  assign last_ret_o   = (ret_cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_fill_arbiter.sv
// -----------------------------------------------------------------------------
// mem_fill_arbiter
// Shares one multi-cycle main memory between the I-cache miss path, the
// D-cache miss path and D-side write-through stores. Fixed priority:
// store > D miss > I miss. A miss is block-aligned and fetched with
// WORDS_PER_BLOCK pipelined reads; returned words are steered to the owning
// cache's fill port.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_miss_req/i_miss_addr          I-cache miss request and byte address
//   d_miss_req/d_miss_addr          D-cache miss request and byte address
//   d_wr_req/d_wr_addr/d_wr_data    write-through store
//   mem_data_out/mem_data_valid     memory read return
//   mem_enable/mem_wr/mem_addr/mem_data_in   memory command
//   i_fill_we/i_fill_word, d_fill_we/d_fill_word, fill_data   fill ports
//   i_fill_done/d_fill_done         one-cycle block-complete pulses
//   d_wr_ack                        one-cycle store-performed pulse
// -----------------------------------------------------------------------------
module mem_fill_arbiter
  import mem_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_miss_req,
  input  logic [ADDR_W-1:0]                  i_miss_addr,
  input  logic                               d_miss_req,
  input  logic [ADDR_W-1:0]                  d_miss_addr,
  input  logic                               d_wr_req,
  input  logic [ADDR_W-1:0]                  d_wr_addr,
  input  logic [DATA_W-1:0]                  d_wr_data,
  input  logic [DATA_W-1:0]                  mem_data_out,
  input  logic                               mem_data_valid,
  output logic                               mem_enable,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_data_in,
  output logic                               i_fill_we,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] i_fill_word,
  output logic                               d_fill_we,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] d_fill_word,
  output logic [DATA_W-1:0]                  fill_data,
  output logic                               i_fill_done,
  output logic                               d_fill_done,
  output logic                               d_wr_ack
);

  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = OFF_W + 1;
  localparam int BLK_W = blk_off_w(WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << BLK_W) - 1);

  arb_state_e        state_q;
  arb_state_e        state_d;
  owner_e            owner_q;
  owner_e            owner_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] base_d;

  logic [CNT_W-1:0]  issue_cnt_s;
  logic [OFF_W-1:0]  ret_word_s;
  logic              last_issue_s;
  logic              last_ret_s;
  logic              fill_active_s;
  logic              issuing_s;
  logic              cnt_clr_s;

  // Returns only count while a block fill owns the memory; stray valids
  // in IDLE/WRITE/DONE are dropped here.
  assign fill_active_s = mem_data_valid &&
                         ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign issuing_s     = (state_q == ST_ISSUE);
  assign cnt_clr_s     = (state_q == ST_IDLE) || (state_q == ST_DONE);

  mem_fill_arbiter_block_fill_counter #(
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_block_fill_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (cnt_clr_s),
    .issue_inc_i  (issuing_s),
    .ret_inc_i    (fill_active_s),
    .issue_cnt_o  (issue_cnt_s),
    .ret_word_o   (ret_word_s),
    .last_issue_o (last_issue_s),
    .last_ret_o   (last_ret_s)
  );

  // State, owner and block-base registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_I;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

  // Next-state: arbitration in IDLE, block-progress tracking otherwise.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (d_wr_req) begin
          state_d = ST_WRITE;
        end else if (d_miss_req) begin
          state_d = ST_ISSUE;
          owner_d = OWNER_D;
          base_d  = d_miss_addr & BLK_MASK;
        end else if (i_miss_req) begin
          state_d = ST_ISSUE;
          owner_d = OWNER_I;
          base_d  = i_miss_addr & BLK_MASK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_ISSUE: begin
        // With a very short memory the final return can coincide with the
        // final issue; go straight to DONE in that case.
        if (last_issue_s) begin
          if (fill_active_s && last_ret_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (fill_active_s && last_ret_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: memory command decoded from state, fill steering from returns.
  always_comb begin
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    d_wr_ack    = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_word = '0;
    d_fill_word = '0;
    fill_data   = '0;
    case (state_q)
      ST_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_data_in = d_wr_data;
        d_wr_ack    = 1'b1;
      end
      ST_ISSUE: begin
        mem_enable = 1'b1;
        mem_addr   = base_q + ADDR_W'({issue_cnt_s, 1'b0});
      end
      ST_DONE: begin
        if (owner_q == OWNER_D) begin
          d_fill_done = 1'b1;
        end else begin
          i_fill_done = 1'b1;
        end
      end
      default: begin
        mem_enable = 1'b0;
      end
    endcase
    if (fill_active_s) begin
      fill_data = mem_data_out;
      if (owner_q == OWNER_D) begin
        d_fill_we   = 1'b1;
        d_fill_word = ret_word_s;
      end else begin
        i_fill_we   = 1'b1;
        i_fill_word = ret_word_s;
      end
    end else begin
      fill_data = '0;
    end
  end

endmodule
